// File: rtl/mul_sched_pkg.sv
// ---------------------------------------------------------------------------
// mul_sched_pkg
// Shared types and helpers for the multiplier-sharing scheduler.
//   OPW      operand width of the shared multiplier
//   PW       product width delivered on the response channel
//   IDW_MAX  id field width in the stage structs (enough for up to 8 requesters)
//   s1_t     operand stage   {valid, id, a, b}
//   s2_t     product stage   {valid, id, prod}
//   next_ptr round-robin pointer advance, wraps at nreq
// ---------------------------------------------------------------------------
package mul_sched_pkg;

   localparam int OPW     = 16;
   localparam int PW      = 33;
   localparam int IDW_MAX = 3;

   typedef struct packed {
      logic               valid;
      logic [IDW_MAX-1:0] id;
      logic [OPW-1:0]     a;
      logic [OPW-1:0]     b;
   } s1_t;

   typedef struct packed {
      logic               valid;
      logic [IDW_MAX-1:0] id;
      logic [PW-1:0]      prod;
   } s2_t;

   // Pointer moves to the requester just after the one granted.
   function automatic logic [IDW_MAX-1:0] next_ptr(input logic [IDW_MAX-1:0] g,
                                                   input int                 nreq);
      if (int'(g) >= nreq - 1) return '0;
      return g + IDW_MAX'(1);
   endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin arbiter. The search starts at i_ptr and wraps
// modulo NREQ; the first asserted request wins.
//   i_req  [NREQ] request vector
//   i_ptr  [IDW]  requester with highest priority this cycle
//   i_en          grant enable (low while the downstream pipeline is stalled)
//   o_gnt  [NREQ] one-hot grant, all zero when disabled or nothing requested
//   o_idx  [IDW]  encoded winner (valid when o_any)
//   o_any         at least one request present, independent of i_en
// ---------------------------------------------------------------------------
module rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   // One extra bit so ptr+k cannot overflow before the modulo fold.
   logic [IDW:0] w_cand;

   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      w_cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = {1'b0, i_ptr} + (IDW+1)'(k);
         if (w_cand >= (IDW+1)'(NREQ)) w_cand = w_cand - (IDW+1)'(NREQ);
         if (!o_any && i_req[w_cand[IDW-1:0]]) begin
            o_any = 1'b1;
            o_idx = w_cand[IDW-1:0];
         end
      end
   end

   assign o_gnt = (i_en && o_any) ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/wallacemultiplier.sv
// ---------------------------------------------------------------------------
// wallacemultiplier
// Combinational unsigned 16x16 multiplier with a 33-bit zero-extended result.
//   i_a    [16] operand A
//   i_b    [16] operand B
//   o_prod [33] {1'b0, i_a*i_b}; bit 32 is always zero
// ---------------------------------------------------------------------------
module wallacemultiplier (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [32:0] o_prod
);

   logic [31:0] w_p;

   assign w_p    = 32'(i_a) * 32'(i_b);
   assign o_prod = {1'b0, w_p};

endmodule

// File: rtl/mul_share_sched.sv
// ---------------------------------------------------------------------------
// mul_share_sched
// Shares one combinational multiplier among NREQ requesters. One request is
// granted per cycle (round robin), operands are registered (S1), multiplied,
// and the product is registered (S2), which drives the tagged response.
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester handshake, req_ready one-hot
//   req_a, req_b            packed operands, requester i in [16i+15:16i]
//   resp_valid/resp_ready   response handshake
//   resp_id, resp_data      requester index and 33-bit product
//   op_count                completed response handshakes, wraps
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both high; the producer holds its payload while
// valid & ~ready, and ready never rises for a requester that is not valid.
// ---------------------------------------------------------------------------
module mul_share_sched
   import mul_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*16-1:0] req_a,
   input  logic [NREQ*16-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   output logic               resp_valid,
   output logic [IDW-1:0]     resp_id,
   output logic [32:0]        resp_data,
   input  logic               resp_ready,
   output logic [15:0]        op_count
);

   s1_t            r_s1;
   s2_t            r_s2;
   logic [IDW-1:0] r_ptr;
   logic [15:0]    r_op_count;

   logic            w_stall;
   logic            w_any;
   logic            w_accept;
   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic [OPW-1:0]  w_a;
   logic [OPW-1:0]  w_b;
   logic [PW-1:0]   w_prod;
   logic            w_unused_id_bits;

   // The whole pipeline freezes only when a result is waiting for the consumer.
   assign w_stall  = r_s2.valid & ~resp_ready;
   assign w_accept = w_any & ~w_stall;

   rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .i_en  (~w_stall),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Operand mux driven by the encoded winner.
   assign w_a = req_a[OPW*w_idx +: OPW];
   assign w_b = req_b[OPW*w_idx +: OPW];

   wallacemultiplier u_mul (
      .i_a    (r_s1.a),
      .i_b    (r_s1.b),
      .o_prod (w_prod)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_ptr      <= '0;
         r_op_count <= '0;
      end else begin
         // S1 and S2 advance together, so S1 may reload even when occupied.
         if (!w_stall) begin
            r_s1 <= '{valid: w_accept, id: IDW_MAX'(w_idx), a: w_a, b: w_b};
            r_s2 <= '{valid: r_s1.valid, id: r_s1.id, prod: w_prod};
         end
         if (w_accept) r_ptr <= IDW'(next_ptr(IDW_MAX'(w_idx), NREQ));
         if (r_s2.valid && resp_ready) r_op_count <= r_op_count + 16'd1;
      end
   end

   // Id bits above IDW are always zero when NREQ < 8.
   assign w_unused_id_bits = ^r_s2.id;

   assign req_ready  = w_gnt;
   assign resp_valid = r_s2.valid;
   assign resp_id    = r_s2.id[IDW-1:0];
   assign resp_data  = r_s2.prod;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_mul_share_sched.sv
// ---------------------------------------------------------------------------
// tb_mul_share_sched
// Directed bench for mul_share_sched (NREQ=4): reset values, single op,
// maximum operands, round-robin order, backpressure, reset mid-flight and
// op_count wrap. A scoreboard queue tracks every accepted request and is
// matched against every response handshake.
// ---------------------------------------------------------------------------
module tb_mul_share_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   // ---------------- clock / reset ----------------
   logic               clk = 1'b0;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*16-1:0] req_b;
   logic [NREQ-1:0]    req_ready;
   logic               resp_valid;
   logic [IDW-1:0]     resp_id;
   logic [32:0]        resp_data;
   logic               resp_ready;
   logic [15:0]        op_count;

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before the end of the sequence");
      $fatal(1, "watchdog");
   end

   mul_share_sched #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .op_count   (op_count)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
      req_valid[i]       = v;
      req_a[16*i +: 16]  = a;
      req_b[16*i +: 16]  = b;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
   endtask

   // ---------------- scoreboard ----------------
   logic [34:0] exp_q[$];
   logic [34:0] sb_item;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         check("rdy_onehot", 64'($onehot0(req_ready)), 64'd1);
         check("rdy_no_valid", 64'(req_ready & ~req_valid), 64'd0);
         if (resp_valid && !resp_ready) check("rdy_stall", 64'(req_ready), 64'd0);
         if (resp_valid) check("resp_bit32", 64'(resp_data[32]), 64'd0);
         if (resp_valid && resp_ready) begin
            check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               sb_item = exp_q.pop_front();
               check("sb_id", 64'(resp_id), 64'(sb_item[34:33]));
               check("sb_data", 64'(resp_data), 64'(sb_item[32:0]));
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i])
               exp_q.push_back({2'(i), 1'b0,
                                32'(req_a[16*i +: 16]) * 32'(req_b[16*i +: 16])});
         end
      end
   end

   // ---------------- directed sequence ----------------
   logic [32:0] rr_prod [4];
   logic        bp_rr   [10];
   logic        bp_v    [10];
   int          bp_a    [10];
   logic [3:0]  bp_gnt  [10];
   logic        bp_rv   [10];
   int          bp_d    [10];

   initial begin
      rr_prod = '{33'd20000, 33'd20301, 33'd20604, 33'd20909};
      bp_rr   = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
      bp_v    = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
      bp_a    = '{7, 8, 9, 9, 9, 9, 10, 0, 0, 0};
      bp_gnt  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                  4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      bp_rv   = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
      bp_d    = '{0, 0, 77, 77, 77, 77, 88, 99, 110, 0};

      // Reset values
      rst_n      = 1'b0;
      resp_ready = 1'b0;
      clear_reqs();
      repeat (3) tick();
      sample();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_id", 64'(resp_id), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
      tick();
      rst_n      = 1'b1;
      resp_ready = 1'b1;

      // Single op: 3*5 from requester 0, result two cycles after accept
      tick(); set_req(0, 1'b1, 16'd3, 16'd5);
      sample(); check("single_grant", 64'(req_ready), 64'b0001);
      tick(); clear_reqs();
      sample(); check("single_lat1_valid", 64'(resp_valid), 64'd0);
      tick();
      sample();
      check("single_valid", 64'(resp_valid), 64'd1);
      check("single_id", 64'(resp_id), 64'd0);
      check("single_data", 64'(resp_data), 64'd15);
      tick();
      sample();
      check("single_done_valid", 64'(resp_valid), 64'd0);
      check("single_op_count", 64'(op_count), 64'd1);

      // Maximum operands from requester 2
      tick(); set_req(2, 1'b1, 16'hFFFF, 16'hFFFF);
      sample(); check("max_grant", 64'(req_ready), 64'b0100);
      tick(); clear_reqs();
      tick();
      sample();
      check("max_valid", 64'(resp_valid), 64'd1);
      check("max_id", 64'(resp_id), 64'd2);
      check("max_data", 64'(resp_data), 64'h0_FFFE_0001);
      check("max_bit32", 64'(resp_data[32]), 64'd0);
      tick();
      sample(); check("max_op_count", 64'(op_count), 64'd2);

      // Reset pulse: pointer (was 3) must return to 0
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      sample();
      check("rst2_op_count", 64'(op_count), 64'd0);
      check("rst2_resp_valid", 64'(resp_valid), 64'd0);

      // Round robin: all four valid for 8 cycles
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 0)
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(100 + i), 16'(200 + i));
         if (k == 8) clear_reqs();
         sample();
         if (k < 8) check("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         if (k >= 2) begin
            check("rr_valid", 64'(resp_valid), 64'd1);
            check("rr_id", 64'(resp_id), 64'((k - 2) % 4));
            check("rr_data", 64'(resp_data), 64'(rr_prod[(k - 2) % 4]));
         end
      end
      tick();
      sample();
      check("rr_drain_valid", 64'(resp_valid), 64'd0);
      check("rr_op_count", 64'(op_count), 64'd8);

      // Backpressure: stream from requester 1, consumer stalls 3 cycles
      for (int c = 0; c < 10; c++) begin
         tick();
         resp_ready = bp_rr[c];
         set_req(1, bp_v[c], 16'(bp_a[c]), 16'd11);
         sample();
         check("bp_grant", 64'(req_ready), 64'(bp_gnt[c]));
         check("bp_valid", 64'(resp_valid), 64'(bp_rv[c]));
         if (bp_rv[c]) begin
            check("bp_id", 64'(resp_id), 64'd1);
            check("bp_data", 64'(resp_data), 64'(bp_d[c]));
         end
      end
      check("bp_op_count", 64'(op_count), 64'd12);

      // Reset mid-flight: two ops in the pipe, then reset
      tick(); clear_reqs(); set_req(0, 1'b1, 16'd2, 16'd2);
      sample(); check("mf_grant_a", 64'(req_ready), 64'b0001);
      tick(); set_req(0, 1'b1, 16'd3, 16'd3);
      sample(); check("mf_grant_b", 64'(req_ready), 64'b0001);
      tick(); clear_reqs(); rst_n = 1'b0; resp_ready = 1'b0;
      tick(); rst_n = 1'b1; resp_ready = 1'b1; set_req(3, 1'b1, 16'd4, 16'd5);
      sample();
      check("mf_resp_valid", 64'(resp_valid), 64'd0);
      check("mf_resp_data", 64'(resp_data), 64'd0);
      check("mf_op_count", 64'(op_count), 64'd0);
      check("mf_grant3", 64'(req_ready), 64'b1000);
      tick(); clear_reqs();
      sample(); check("mf_no_stale", 64'(resp_valid), 64'd0);
      tick();
      sample();
      check("mf_valid", 64'(resp_valid), 64'd1);
      check("mf_id", 64'(resp_id), 64'd3);
      check("mf_data", 64'(resp_data), 64'd20);
      tick();
      sample(); check("mf_op_count1", 64'(op_count), 64'd1);

      // op_count wrap: 65534 more ops reach 0xFFFF, one more wraps to 0
      tick(); set_req(0, 1'b1, 16'd1, 16'd1);
      repeat (65533) tick();
      tick(); clear_reqs();
      tick();
      tick();
      sample();
      check("wrap_pre_count", 64'(op_count), 64'hFFFF);
      check("wrap_pre_valid", 64'(resp_valid), 64'd0);
      tick(); set_req(0, 1'b1, 16'd6, 16'd7);
      sample(); check("wrap_grant", 64'(req_ready), 64'b0001);
      tick(); clear_reqs();
      tick();
      sample(); check("wrap_data", 64'(resp_data), 64'd42);
      tick();
      sample(); check("wrap_op_count", 64'(op_count), 64'd0);

      // ---------------- final report ----------------
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
